// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
// Steps through a song made of bars of 2**ROW_BITS rows. Each row is eight
// sub-ticks long. At the start of a row the sequencer fetches the pattern row
// from an external store and turns the returned per-voice "note present" bits
// into one-cycle note_load strobes and envelope gates. All gates drop at sub-tick
// GATE_OFF_SUB. If a fetch has not completed by the next row boundary, the
// sticky overrun flag is raised and the fetch moves on to the new row.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   tick_clock  divided tick level, 8 sub-ticks per row (clk-synchronous)
//   play        1 = run, 0 = stop at the next row boundary
//   last_bar    index of the final bar; the song loops back to bar 0 after it
//   rd_req      pattern-row fetch request
//   rd_bar      bar address of the fetch
//   rd_row      row address of the fetch
//   rd_ack      one-cycle fetch completion (latency unbounded)
//   rd_note     per-voice note-present bits, valid with rd_ack
//   note_load   one-cycle strobe per voice: latch new pitch
//   gate        envelope gate per voice
//   overrun     sticky: a fetch did not complete within its row
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter int NUM_VOICES   = 3,
    parameter int BAR_BITS     = 4,
    parameter int ROW_BITS     = 4,
    parameter int GATE_OFF_SUB = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_clock,
    input  logic                  play,
    input  logic [BAR_BITS-1:0]   last_bar,
    output logic                  rd_req,
    output logic [BAR_BITS-1:0]   rd_bar,
    output logic [ROW_BITS-1:0]   rd_row,
    input  logic                  rd_ack,
    input  logic [NUM_VOICES-1:0] rd_note,
    output logic [NUM_VOICES-1:0] note_load,
    output logic [NUM_VOICES-1:0] gate,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    localparam logic [2:0]          GATE_OFF = 3'(GATE_OFF_SUB);
    localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
    localparam logic [BAR_BITS-1:0] BAR_ONE  = BAR_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_MAX  = {ROW_BITS{1'b1}};
    localparam logic [ROW_BITS-1:0] ROW_ZERO = {ROW_BITS{1'b0}};
    localparam logic [BAR_BITS-1:0] BAR_ZERO = {BAR_BITS{1'b0}};
    localparam logic [NUM_VOICES-1:0] V_ZERO = {NUM_VOICES{1'b0}};

    state_t                r_state;
    logic                  r_tick_q;
    logic [2:0]            r_sub;
    logic [ROW_BITS-1:0]   r_row;
    logic [BAR_BITS-1:0]   r_bar;
    logic                  r_rd_req;
    logic [BAR_BITS-1:0]   r_rd_bar;
    logic [ROW_BITS-1:0]   r_rd_row;
    logic [NUM_VOICES-1:0] r_note_load;
    logic [NUM_VOICES-1:0] r_gate;
    logic                  r_overrun;

    logic                  w_tick_edge;
    logic [2:0]            w_sub_next;
    logic                  w_boundary;
    logic                  w_ack_ok;
    logic                  w_gate_off;
    logic [ROW_BITS-1:0]   w_row_next;
    logic [BAR_BITS-1:0]   w_bar_next;
    logic [NUM_VOICES-1:0] w_gate_next;

    // Next-position, tick-edge and gate update decode
    always_comb begin
        w_tick_edge = tick_clock & ~r_tick_q;
        w_sub_next  = r_sub + 3'd1;
        w_boundary  = w_tick_edge && (r_sub == 3'd7);
        // Only an ack against a live request counts; the gap cycle after an
        // abandoned fetch and acks in IDLE/PLAY are spurious.
        w_ack_ok    = (r_state == S_FETCH) && r_rd_req && rd_ack;
        w_gate_off  = w_tick_edge && (w_sub_next == GATE_OFF);
        w_row_next  = r_row + ROW_ONE;
        // Bar wraps on equality only, so a bar already above a freshly lowered
        // last_bar keeps counting until its own counter wraps to zero.
        if (r_row == ROW_MAX) begin
            w_bar_next = (r_bar == last_bar) ? BAR_ZERO : (r_bar + BAR_ONE);
        end else begin
            w_bar_next = r_bar;
        end
        // A note arriving on the same edge as gate-off is cut by the gate-off.
        if (w_gate_off) begin
            w_gate_next = V_ZERO;
        end else if (w_ack_ok) begin
            w_gate_next = r_gate | rd_note;
        end else begin
            w_gate_next = r_gate;
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tick_q    <= 1'b0;
            r_sub       <= 3'd0;
            r_row       <= ROW_ZERO;
            r_bar       <= BAR_ZERO;
            r_rd_req    <= 1'b0;
            r_rd_bar    <= BAR_ZERO;
            r_rd_row    <= ROW_ZERO;
            r_note_load <= V_ZERO;
            r_gate      <= V_ZERO;
            r_overrun   <= 1'b0;
        end else begin
            r_tick_q    <= tick_clock;
            r_note_load <= V_ZERO;
            case (r_state)
                S_IDLE: begin
                    if (w_tick_edge && play) begin
                        r_state  <= S_FETCH;
                        r_sub    <= 3'd0;
                        r_rd_req <= 1'b1;
                        r_rd_bar <= r_bar;
                        r_rd_row <= r_row;
                    end
                end
                S_FETCH, S_PLAY: begin
                    if (w_tick_edge) begin
                        r_sub <= w_sub_next;
                    end
                    r_gate <= w_gate_next;
                    if (w_ack_ok) begin
                        r_note_load <= rd_note;
                        r_rd_req    <= 1'b0;
                        r_state     <= S_PLAY;
                    end else if ((r_state == S_FETCH) && !r_rd_req) begin
                        // Re-issue after the one-cycle gap of an abandoned fetch.
                        r_rd_req <= 1'b1;
                    end
                    if (w_boundary) begin
                        if ((r_state == S_FETCH) && !w_ack_ok) begin
                            r_overrun <= 1'b1;
                        end
                        if (play) begin
                            r_row    <= w_row_next;
                            r_bar    <= w_bar_next;
                            r_state  <= S_FETCH;
                            r_rd_bar <= w_bar_next;
                            r_rd_row <= w_row_next;
                            // A fetch still pending is dropped for one cycle
                            // before the new row is requested.
                            r_rd_req <= (r_state == S_PLAY) || w_ack_ok;
                        end else begin
                            r_row    <= ROW_ZERO;
                            r_bar    <= BAR_ZERO;
                            r_state  <= S_IDLE;
                            r_gate   <= V_ZERO;
                            r_rd_req <= 1'b0;
                            r_rd_bar <= BAR_ZERO;
                            r_rd_row <= ROW_ZERO;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

    assign rd_req    = r_rd_req;
    assign rd_bar    = r_rd_bar;
    assign rd_row    = r_rd_row;
    assign note_load = r_note_load;
    assign gate      = r_gate;
    assign overrun   = r_overrun;

endmodule
